// File: rtl/attn_seq_pkg.sv
// Shared state encoding, Q8.8 constants and sizing helper for the attention token sequencer.
package attn_seq_pkg;

  typedef enum logic [1:0] {
    ST_GATHER = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DRAIN  = 2'd3
  } seq_state_e;

  localparam logic signed [15:0] ONE = 16'sd256;

  // Index counters never collapse to zero width, even for a single-element vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/attn_watchdog.sv
// Response watchdog: cleared on issue, counts while enabled, flags expiry on the TIMEOUT-th idle count.
// Combinational expire flag, zero added latency; no handshake of its own.
module attn_watchdog #(
  parameter int TIMEOUT = 50
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] SAT   = TW'(TIMEOUT);

  logic [TW-1:0] timer_q, timer_d;

  always_comb begin
    timer_d = timer_q;
    if (clr_i) begin
      timer_d = '0;
    end else if (en_i && (timer_q != SAT)) begin
      timer_d = timer_q + TW'(1);
    end
  end

  // Fires during the last idle cycle, so the state change and the error land on the same edge.
  assign expire_o = en_i && !clr_i && (timer_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

endmodule

// File: rtl/attn_token_sequencer.sv
// Gathers one token vector, issues a single-cycle request to attention_unit, drains the response.
// Issue one cycle after the last input beat; drain starts one cycle after attn_valid_out; m_ready stalls hold data.
module attn_token_sequencer
  import attn_seq_pkg::*;
#(
  parameter int EMBED_DIM  = 4,
  parameter int DATA_WIDTH = 16,
  parameter int TIMEOUT    = 50
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [DATA_WIDTH-1:0]           s_data,
  output logic                            attn_valid_in,
  output logic [EMBED_DIM*DATA_WIDTH-1:0] attn_x,
  input  logic                            attn_valid_out,
  input  logic [EMBED_DIM*DATA_WIDTH-1:0] attn_y,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic                            m_last,
  input  logic                            err_clr,
  output logic                            timeout_err,
  output logic [15:0]                     tok_count
);

  localparam int IW = idx_width(EMBED_DIM);
  localparam logic [IW-1:0] LAST_IDX = IW'(EMBED_DIM - 1);

  typedef logic [EMBED_DIM-1:0][DATA_WIDTH-1:0] vec_t;

  seq_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] odx_q, odx_d;
  vec_t          x_q, x_d;
  vec_t          y_q, y_d;
  logic          avi_q, avi_d;
  logic [15:0]   tok_q, tok_d;
  logic          err_q, err_d;
  logic          wd_clr, wd_en, wd_expire;

  attn_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    odx_d   = odx_q;
    x_d     = x_q;
    y_d     = y_q;
    avi_d   = 1'b0;
    tok_d   = tok_q;
    err_d   = err_clr ? 1'b0 : err_q;
    wd_clr  = 1'b0;
    wd_en   = 1'b0;
    case (state_q)
      ST_GATHER: begin
        if (s_valid) begin
          x_d[idx_q] = s_data;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            avi_d   = 1'b1;
            state_d = ST_ISSUE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_ISSUE: begin
        wd_clr  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (attn_valid_out) begin
          y_d     = attn_y;
          odx_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          wd_en = 1'b1;
          // A timeout overrides a simultaneous err_clr.
          if (wd_expire) begin
            err_d   = 1'b1;
            state_d = ST_GATHER;
          end
        end
      end
      ST_DRAIN: begin
        if (m_ready) begin
          if (odx_q == LAST_IDX) begin
            odx_d   = '0;
            tok_d   = tok_q + 16'd1;
            state_d = ST_GATHER;
          end else begin
            odx_d = odx_q + IW'(1);
          end
        end
      end
      default: state_d = ST_GATHER;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_GATHER;
      idx_q   <= '0;
      odx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      avi_q   <= 1'b0;
      tok_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      odx_q   <= odx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      avi_q   <= avi_d;
      tok_q   <= tok_d;
      err_q   <= err_d;
    end
  end

  assign s_ready       = rst_n && (state_q == ST_GATHER);
  assign attn_valid_in = avi_q;
  assign attn_x        = x_q;
  assign m_valid       = (state_q == ST_DRAIN);
  assign m_data        = m_valid ? y_q[odx_q] : '0;
  assign m_last        = m_valid && (odx_q == LAST_IDX);
  assign timeout_err   = err_q;
  assign tok_count     = tok_q;

endmodule
